// File: rtl/irq_pkg.sv
// irq_pkg: shared constants for the IRQ capture front-end and the 4-to-2 priority encoder.
package irq_pkg;
    localparam int N_SRC = 4;
    localparam int IDX_W = 2;
    localparam logic [IDX_W-1:0] IDX_I0 = 2'd0;
    localparam logic [IDX_W-1:0] IDX_I1 = 2'd1;
    localparam logic [IDX_W-1:0] IDX_I2 = 2'd2;
    localparam logic [IDX_W-1:0] IDX_I3 = 2'd3;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: single-bit STAGES-deep synchroniser with asynchronous active-low reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end
    assign q = chain[STAGES-1];
endmodule

// File: rtl/irq_pending_capture.sv
// irq_pending_capture: synchronise, rise-detect and hold four IRQ lines as pending bits for the encoder.
// Define IRQ_OVERFLOW_EN to add sticky per-source overflow flags (ovf) with a global ovf_clr.
module irq_pending_capture
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_raw,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             clr_valid,
    input  logic [IDX_W-1:0] clr_idx,
`ifdef IRQ_OVERFLOW_EN
    input  logic             ovf_clr,
    output logic [N_SRC-1:0] ovf,
`endif
    output logic [N_SRC-1:0] pend,
    output logic             any_pend
);
    if (N_SRC != 4 || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_cfg
        $error("irq_pending_capture: N_SRC must be 4 and SYNC_STAGES must be 2..4");
    end
    logic [N_SRC-1:0] s, prev, set, clr;
    for (genvar k = 0; k < N_SRC; k++) begin : g_sync
        sync_bit #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(irq_raw[k]), .q(s[k]));
    end
    always_comb begin
        set = s & ~prev & irq_mask;
        clr = clr_valid ? N_SRC'(1) << clr_idx : '0;
    end
    // set is ORed after the clear so a fresh edge is never lost to a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            pend <= '0;
        end else begin
            prev <= s;
            pend <= (pend & ~clr) | set;
        end
    end
`ifdef IRQ_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= '0;
        else        ovf <= (ovf & ~{N_SRC{ovf_clr}}) | (set & pend & ~clr);
    end
`endif
    assign any_pend = |pend;
endmodule
